// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the byte-wide Ethernet transmit framer.
package mac_tx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StSfd,
      StData,
      StPad,
      StFcs,
      StDrain,
      StIfg
   } tx_state_e;

   localparam logic [7:0]  PREAMBLE    = 8'h55;
   localparam logic [7:0]  SFD         = 8'hD5;
   localparam int unsigned MIN_FRAME   = 60;
   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

endpackage

// File: rtl/mac_tx_framer_if.sv
// Client MAC TX handshake plus GMII transmit and frame status signals.
interface mac_tx_framer_if;

   logic [7:0] mac_tx_data;
   logic       mac_tx_dvld;
   logic       mac_tx_ack;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       tx_frame_done;
   logic       tx_frame_err;

   modport master (
      output mac_tx_data, mac_tx_dvld,
      input  mac_tx_ack, gmii_txd, gmii_tx_en, gmii_tx_er, tx_frame_done, tx_frame_err
   );

   modport slave (
      input  mac_tx_data, mac_tx_dvld,
      output mac_tx_ack, gmii_txd, gmii_tx_en, gmii_tx_er, tx_frame_done, tx_frame_err
   );

endinterface

// File: rtl/crc32_d8.sv
// Combinational CRC-32 step over one byte, reflected polynomial, LSB first.
module crc32_d8
   import mac_tx_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   always_comb begin : p_crc
      logic [31:0] c;
      c = crc_i;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data_i[i]) begin
            c = (c >> 1) ^ CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      crc_o = c;
   end

endmodule

// File: rtl/mac_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS and inter-frame gap.
module mac_tx_framer
   import mac_tx_pkg::*;
#(
   parameter int unsigned IFG_BYTES = 12,
   parameter int unsigned MAX_STD   = 1514,
   parameter int unsigned MAX_JUMBO = 9014
) (
   input  logic           tx_clk,
   input  logic           reset,
   input  logic           conf_tx_en,
   input  logic           conf_tx_jumbo_en,
   input  logic           conf_tx_no_gen_crc,
   mac_tx_framer_if.slave bus
);

   localparam logic [7:0]  IfgLast  = 8'(IFG_BYTES - 1);
   localparam logic [13:0] MinFrame = 14'(MIN_FRAME);

   tx_state_e   state_q, state_d;
   logic [13:0] byte_cnt_q, byte_cnt_d, byte_inc, max_len;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] crc_q, crc_d, crc_upd;
   logic [7:0]  crc_byte;
   logic        jumbo_q, jumbo_d, no_crc_q, no_crc_d;
   logic [7:0]  txd_q, txd_d;
   logic        en_q, en_d, er_q, er_d, ack_q, ack_d, done_q, done_d, err_q, err_d;
   logic        start_ok, go_idle, abort, end_payload;

   assign start_ok = bus.mac_tx_dvld & conf_tx_en;
   assign max_len  = jumbo_q ? 14'(MAX_JUMBO) : 14'(MAX_STD);
   assign byte_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 14'd1;
   // Pad bytes are zero; the data path otherwise folds in the byte being captured.
   assign crc_byte = ((state_q == StPad) || ((state_q == StData) && !bus.mac_tx_dvld)) ?
                     8'h00 : bus.mac_tx_data;

   crc32_d8 u_crc (
      .crc_i  (crc_q),
      .data_i (crc_byte),
      .crc_o  (crc_upd)
   );

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      cnt_d       = cnt_q;
      crc_d       = crc_q;
      jumbo_d     = jumbo_q;
      no_crc_d    = no_crc_q;
      txd_d       = 8'h00;
      en_d        = 1'b0;
      er_d        = 1'b0;
      ack_d       = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      go_idle     = 1'b0;
      abort       = 1'b0;
      end_payload = 1'b0;

      unique case (state_q)
         StIdle: go_idle = 1'b1;
         StPreamble: begin
            if (!bus.mac_tx_dvld) begin
               abort = 1'b1;
            end else if (cnt_q == 8'd6) begin
               state_d = StSfd;
               txd_d   = SFD;
               en_d    = 1'b1;
               ack_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
               txd_d = PREAMBLE;
               en_d  = 1'b1;
            end
         end
         StSfd: begin
            if (!bus.mac_tx_dvld) begin
               abort = 1'b1;
            end else begin
               state_d    = StData;
               txd_d      = bus.mac_tx_data;
               en_d       = 1'b1;
               byte_cnt_d = 14'd1;
               crc_d      = crc_upd;
            end
         end
         StData: begin
            if (bus.mac_tx_dvld && (byte_cnt_q >= max_len)) begin
               state_d = StDrain;
               txd_d   = bus.mac_tx_data;
               en_d    = 1'b1;
               er_d    = 1'b1;
               err_d   = 1'b1;
            end else if (bus.mac_tx_dvld) begin
               txd_d      = bus.mac_tx_data;
               en_d       = 1'b1;
               byte_cnt_d = byte_inc;
               crc_d      = crc_upd;
            end else if (no_crc_q) begin
               state_d = StIfg;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               end_payload = 1'b1;
            end
         end
         StPad: end_payload = 1'b1;
         StFcs: begin
            if (cnt_q == 8'd3) begin
               state_d = StIfg;
               cnt_d   = '0;
            end else begin
               cnt_d  = cnt_q + 8'd1;
               txd_d  = ~crc_q[7:0];
               crc_d  = crc_q >> 8;
               en_d   = 1'b1;
               done_d = (cnt_q == 8'd2);
            end
         end
         StDrain: begin
            if (!bus.mac_tx_dvld) begin
               state_d = StIfg;
               cnt_d   = '0;
            end
         end
         StIfg: begin
            if (cnt_q == IfgLast) begin
               go_idle = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (abort) begin
         state_d = StIfg;
         cnt_d   = '0;
         err_d   = 1'b1;
      end

      if (end_payload) begin
         en_d = 1'b1;
         if (byte_cnt_q < MinFrame) begin
            state_d    = StPad;
            byte_cnt_d = byte_inc;
            crc_d      = crc_upd;
         end else begin
            // FCS goes out low byte first; shift the register down as each byte leaves.
            state_d = StFcs;
            cnt_d   = '0;
            txd_d   = ~crc_q[7:0];
            crc_d   = crc_q >> 8;
         end
      end

      // Final IFG edge doubles as the idle check so back-to-back gaps are exactly IFG_BYTES.
      if (go_idle) begin
         state_d = StIdle;
         if (start_ok) begin
            state_d    = StPreamble;
            cnt_d      = '0;
            byte_cnt_d = '0;
            crc_d      = CRC_INIT;
            jumbo_d    = conf_tx_jumbo_en;
            no_crc_d   = conf_tx_no_gen_crc;
            txd_d      = PREAMBLE;
            en_d       = 1'b1;
         end
      end
   end

   always_ff @(posedge tx_clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         byte_cnt_q <= '0;
         cnt_q      <= '0;
         crc_q      <= CRC_INIT;
         jumbo_q    <= 1'b0;
         no_crc_q   <= 1'b0;
         txd_q      <= 8'h00;
         en_q       <= 1'b0;
         er_q       <= 1'b0;
         ack_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         jumbo_q    <= jumbo_d;
         no_crc_q   <= no_crc_d;
         txd_q      <= txd_d;
         en_q       <= en_d;
         er_q       <= er_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.gmii_txd      = txd_q;
   assign bus.gmii_tx_en    = en_q;
   assign bus.gmii_tx_er    = er_q;
   assign bus.mac_tx_ack    = ack_q;
   assign bus.tx_frame_done = done_q;
   assign bus.tx_frame_err  = err_q;

endmodule
